// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download arbiter: port select, FIFO entry and FSM state.
package rom_dl_pkg;

  typedef enum logic {
    SEL_P1,
    SEL_P2
  } port_sel_e;

  typedef struct packed {
    port_sel_e   sel;
    logic [24:0] addr;
    logic [7:0]  data;
  } fifo_entry_t;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

endpackage

// File: rtl/rom_dl_fifo.sv
// Small synchronous first-word-fall-through FIFO of download entries.
module rom_dl_fifo
  import rom_dl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          i_push,
  input  fifo_entry_t                   i_din,
  input  logic                          i_pop,
  output fifo_entry_t                   o_dout,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  fifo_entry_t   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];

  assign w_wr = i_push & ~o_full;
  assign w_rd = i_pop & ~o_empty;

  always_ff @(posedge clk_sys) begin
    if (w_wr) begin
      r_mem[r_wp] <= i_din;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/rom_download_arbiter.sv
// Buffers ioctl download bytes and issues them, one toggle handshake at a time,
// to the CPU ROM port (port1) or the interleaved 32-bit gfx ROM port (port2).
module rom_download_arbiter
  import rom_dl_pkg::*;
#(
  parameter logic [24:0] P2_BASE    = 25'h00E000,
  parameter logic [24:0] P2_SIZE    = 25'h008000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        reset_req,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port1_we,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [13:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        port2_we,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        overflow,
  output logic        dropped
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_e      r_state;
  state_e      w_state_nxt;
  port_sel_e   r_sel;
  logic        r_wr_d;
  logic        r_downl_d;
  logic        r_fall_seen;
  logic        r_rom_loaded;
  logic        r_core_reset;
  logic        r_overflow;
  logic        r_dropped;
  logic        r_p1_req;
  logic [22:0] r_p1_a;
  logic [1:0]  r_p1_ds;
  logic [15:0] r_p1_d;
  logic        r_p2_req;
  logic [13:0] r_p2_a;
  logic [1:0]  r_p2_ds;
  logic [15:0] r_p2_d;

  logic          w_cap;
  logic          w_to_p1;
  logic          w_to_p2;
  logic          w_routed;
  logic          w_push;
  logic          w_issue;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [25:0]   w_p2_end;
  logic [14:0]   w_off;
  logic          w_ack_match;
  logic          w_rise;
  logic          w_fall;
  logic          w_busy;
  fifo_entry_t   w_din;
  fifo_entry_t   w_head;

  assign w_cap    = ioctl_wr & ~r_wr_d & ioctl_downl;
  assign w_p2_end = {1'b0, P2_BASE} + {1'b0, P2_SIZE};
  assign w_to_p1  = (ioctl_addr < P2_BASE);
  assign w_to_p2  = ~w_to_p1 & ({1'b0, ioctl_addr} < w_p2_end);
  assign w_routed = w_to_p1 | w_to_p2;
  assign w_push   = w_cap & w_routed & ~w_full;

  assign w_din = '{sel: (w_to_p1 ? SEL_P1 : SEL_P2), addr: ioctl_addr, data: ioctl_dout};

  rom_dl_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_issue),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Only the low 15 bits of the region offset are mapped, and those depend
  // only on the low 15 bits of the operands.
  assign w_off = w_head.addr[14:0] - P2_BASE[14:0];

  assign w_ack_match = (r_sel == SEL_P1) ? (r_p1_req == port1_ack) : (r_p2_req == port2_ack);

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_issue     = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (w_ack_match) w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_sel    <= SEL_P1;
      r_p1_req <= port1_ack;
      r_p1_a   <= '0;
      r_p1_ds  <= '0;
      r_p1_d   <= '0;
      r_p2_req <= port2_ack;
      r_p2_a   <= '0;
      r_p2_ds  <= '0;
      r_p2_d   <= '0;
    end else if (w_issue) begin
      r_sel <= w_head.sel;
      if (w_head.sel == SEL_P1) begin
        r_p1_req <= ~r_p1_req;
        r_p1_a   <= w_head.addr[23:1];
        r_p1_ds  <= {w_head.addr[0], ~w_head.addr[0]};
        r_p1_d   <= {w_head.data, w_head.data};
      end else begin
        r_p2_req <= ~r_p2_req;
        r_p2_a   <= {w_off[12:0], w_off[14]};
        r_p2_ds  <= {w_off[13], ~w_off[13]};
        r_p2_d   <= {w_head.data, w_head.data};
      end
    end
  end

  assign w_rise = ioctl_downl & ~r_downl_d;
  assign w_fall = ~ioctl_downl & r_downl_d;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wr_d       <= 1'b1;
      r_downl_d    <= 1'b0;
      r_fall_seen  <= 1'b0;
      r_rom_loaded <= 1'b0;
      r_core_reset <= 1'b1;
      r_overflow   <= 1'b0;
      r_dropped    <= 1'b0;
    end else begin
      r_wr_d    <= ioctl_wr;
      r_downl_d <= ioctl_downl;
      if (w_rise)      r_fall_seen <= 1'b0;
      else if (w_fall) r_fall_seen <= 1'b1;
      if (w_rise) begin
        r_rom_loaded <= 1'b0;
      end else if (!ioctl_downl && w_empty && (r_state == IDLE) && (r_fall_seen || w_fall)) begin
        r_rom_loaded <= 1'b1;
      end
      r_core_reset <= reset_req | ~r_rom_loaded | ioctl_downl;
      if (w_cap && w_routed && w_full) r_overflow <= 1'b1;
      if (w_cap && !w_routed)          r_dropped  <= 1'b1;
    end
  end

  assign w_busy = ioctl_downl | (r_state == WAIT) | (w_count != '0);

  assign port1_req  = r_p1_req;
  assign port1_a    = r_p1_a;
  assign port1_ds   = r_p1_ds;
  assign port1_d    = r_p1_d;
  assign port1_we   = ~reset & w_busy;
  assign port2_req  = r_p2_req;
  assign port2_a    = r_p2_a;
  assign port2_ds   = r_p2_ds;
  assign port2_d    = r_p2_d;
  assign port2_we   = ~reset & w_busy;
  assign rom_loaded = r_rom_loaded;
  assign core_reset = r_core_reset;
  assign overflow   = r_overflow;
  assign dropped    = r_dropped;

endmodule

// File: tb/tb_rom_download_arbiter.sv
// Scoreboard bench: stimulus pushes expected port writes, a monitor checks each req toggle.
module tb_rom_download_arbiter;

  localparam int unsigned BASE = 32'h0000E000;
  localparam int unsigned SIZE = 32'h00008000;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_downl = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        reset_req = 1'b0;
  logic        port1_req, port2_req;
  logic        port1_ack = 1'b0, port2_ack = 1'b0;
  logic [22:0] port1_a;
  logic [13:0] port2_a;
  logic [1:0]  port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;
  logic        port1_we, port2_we;
  logic        rom_loaded, core_reset, overflow, dropped;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned tx_count = 0;
  int unsigned ack_dly = 0;
  bit          ack_en = 1'b1;
  bit          exp_dropped = 1'b0;
  logic [41:0] sb[$];

  always #5 clk_sys = ~clk_sys;

  rom_download_arbiter #(
    .P2_BASE    (25'h00E000),
    .P2_SIZE    (25'h008000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .reset_req(reset_req),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a), .port1_ds(port1_ds),
    .port1_d(port1_d), .port1_we(port1_we),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a), .port2_ds(port2_ds),
    .port2_d(port2_d), .port2_we(port2_we),
    .rom_loaded(rom_loaded), .core_reset(core_reset), .overflow(overflow), .dropped(dropped)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference mapping from the address-region rules; returns 0 for out-of-range bytes.
  function automatic bit model_route(input int unsigned addr, input int unsigned data,
                                     output logic [41:0] t);
    int unsigned off, a, ds, d;
    d = (data % 256) * 257;
    t = '0;
    if (addr < BASE) begin
      a  = addr / 2;
      ds = (addr % 2 == 1) ? 2 : 1;
      t  = {1'b0, 23'(a), 2'(ds), 16'(d)};
      return 1'b1;
    end else if (addr < BASE + SIZE) begin
      off = addr - BASE;
      a   = (off % 8192) * 2 + (off / 16384) % 2;
      ds  = ((off / 8192) % 2 == 1) ? 2 : 1;
      t   = {1'b1, 23'(a), 2'(ds), 16'(d)};
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic send_byte(input int unsigned addr, input int unsigned data,
                           input int unsigned gap, input bit keep);
    logic [41:0] t;
    @(negedge clk_sys);
    ioctl_addr = 25'(addr);
    ioctl_dout = 8'(data);
    ioctl_wr   = 1'b1;
    if (model_route(addr, data, t)) begin
      if (keep) sb.push_back(t);
    end else begin
      exp_dropped = 1'b1;
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (gap) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    ioctl_wr    = 1'b0;
    ioctl_downl = 1'b0;
    @(negedge clk_sys);
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    exp_dropped = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int unsigned limit);
    int unsigned n = 0;
    while ((sb.size() != 0 || port1_req != port1_ack || port2_req != port2_ack) && n < limit) begin
      @(negedge clk_sys);
      n++;
    end
    chk({name, "_pending"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_loaded(input string name, input int unsigned limit);
    int unsigned n = 0;
    while (rom_loaded !== 1'b1 && n < limit) begin
      @(negedge clk_sys);
      n++;
    end
    chk({name, "_rom_loaded"}, 64'(rom_loaded), 64'd1);
  endtask

  // Ack responder: echoes req after ack_dly cycles of observed mismatch.
  initial begin
    int unsigned c1, c2;
    c1 = 0;
    c2 = 0;
    forever begin
      @(negedge clk_sys);
      if (ack_en && port1_req !== port1_ack) begin
        if (c1 >= ack_dly) begin port1_ack = port1_req; c1 = 0; end else c1++;
      end else c1 = 0;
      if (ack_en && port2_req !== port2_ack) begin
        if (c2 >= ack_dly) begin port2_ack = port2_req; c2 = 0; end else c2++;
      end else c2 = 0;
    end
  end

  // Monitor: every req toggle must match the head of the scoreboard.
  initial begin
    logic p1_prev, p2_prev;
    logic [41:0] got, exp;
    p1_prev = 1'b0;
    p2_prev = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (reset !== 1'b1 && (port1_req !== p1_prev || port2_req !== p2_prev)) begin
        tx_count++;
        if (port1_req !== p1_prev && port2_req !== p2_prev)
          chk("both_ports_toggled", 64'd1, 64'd0);
        if (port1_req !== p1_prev) got = {1'b0, port1_a, port1_ds, port1_d};
        else                       got = {1'b1, 9'd0, port2_a, port2_ds, port2_d};
        chk("we_at_issue", 64'(port1_we & port2_we), 64'd1);
        if (sb.size() == 0) begin
          chk("unexpected_txn", 64'(got), 64'h3FFFFFFFFFF);
        end else begin
          exp = sb.pop_front();
          chk("txn", 64'(got), 64'(exp));
        end
      end
      p1_prev = port1_req;
      p2_prev = port2_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned tx0, n, addr, cat;
    bit we_ok, rl_ok;

    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_rom_loaded", 64'(rom_loaded), 64'd0);
    chk("rst_req", 64'({port1_req, port2_req}), 64'd0);
    chk("rst_we", 64'({port1_we, port2_we}), 64'd0);
    chk("rst_flags", 64'({overflow, dropped}), 64'd0);

    // Single port1 byte
    ack_dly = 5;
    tx0 = tx_count;
    ioctl_downl = 1'b1;
    send_byte(32'h1, 32'hA5, 2, 1'b1);
    wait_drain("single", 100);
    chk("single_txn_count", 64'(tx_count - tx0), 64'd1);
    ioctl_downl = 1'b0;
    wait_loaded("single", 20);
    chk("single_core_reset_hold", 64'(core_reset), 64'd1);
    @(negedge clk_sys);
    chk("single_core_reset_drop", 64'(core_reset), 64'd0);

    // Port2 interleave mapping
    ack_dly = 2;
    ioctl_downl = 1'b1;
    send_byte(BASE, 32'h11, 3, 1'b1);
    send_byte(BASE + 1, 32'h22, 3, 1'b1);
    send_byte(BASE + 32'h2000, 32'h33, 3, 1'b1);
    send_byte(BASE + 32'h4000, 32'h44, 3, 1'b1);
    wait_drain("p2map", 100);

    // Boundary and out-of-range bytes
    send_byte(BASE - 1, 32'h55, 3, 1'b1);
    send_byte(BASE + SIZE - 1, 32'h66, 3, 1'b1);
    wait_drain("bounds", 100);
    chk("bounds_dropped", 64'(dropped), 64'd0);
    tx0 = tx_count;
    send_byte(BASE + SIZE, 32'h77, 8, 1'b1);
    chk("oor_no_txn", 64'(tx_count - tx0), 64'd0);
    chk("oor_dropped", 64'(dropped), 64'd1);
    ioctl_downl = 1'b0;
    wait_loaded("oor", 20);

    // Zero-byte download
    @(negedge clk_sys);
    ioctl_downl = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("zero_cleared", 64'(rom_loaded), 64'd0);
    ioctl_downl = 1'b0;
    wait_loaded("zero", 10);

    // Back-pressure: 1 in flight + 4 buffered, 6th byte lost
    do_reset();
    ack_dly = 40;
    tx0 = tx_count;
    ioctl_downl = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(32'h100 + 32'(i), 32'h80 + 32'(i), 2, (i < 5));
    ioctl_downl = 1'b0;
    chk("bp_overflow", 64'(overflow), 64'd1);
    we_ok = 1'b1;
    rl_ok = 1'b1;
    n = 0;
    while ((sb.size() != 0 || port1_req != port1_ack) && n < 400) begin
      if (port1_we !== 1'b1) we_ok = 1'b0;
      if (rom_loaded !== 1'b0) rl_ok = 1'b0;
      @(negedge clk_sys);
      n++;
    end
    chk("bp_we_held", 64'(we_ok), 64'd1);
    chk("bp_loaded_gated", 64'(rl_ok), 64'd1);
    wait_drain("bp", 10);
    chk("bp_txn_count", 64'(tx_count - tx0), 64'd5);
    wait_loaded("bp", 10);

    // Drain gating: downl falls with entries pending
    do_reset();
    ack_dly = 20;
    ioctl_downl = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(BASE + 32'h10 + 32'(i), 32'h90 + 32'(i), 1, 1'b1);
    ioctl_downl = 1'b0;
    rl_ok = 1'b1;
    n = 0;
    while ((sb.size() != 0 || port2_req != port2_ack) && n < 200) begin
      if (rom_loaded !== 1'b0) rl_ok = 1'b0;
      @(negedge clk_sys);
      n++;
    end
    chk("drain_loaded_gated", 64'(rl_ok), 64'd1);
    wait_drain("drain", 10);
    wait_loaded("drain", 4);

    // Reset while a write is outstanding
    ack_en = 1'b0;
    ioctl_downl = 1'b1;
    send_byte(32'h20, 32'h5A, 0, 1'b1);
    n = 0;
    while (port1_req === port1_ack && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    chk("midwait_outstanding", 64'(port1_req != port1_ack), 64'd1);
    do_reset();
    chk("midwait_req_resync", 64'(port1_req == port1_ack), 64'd1);
    chk("midwait_core_reset", 64'(core_reset), 64'd1);
    chk("midwait_rom_loaded", 64'(rom_loaded), 64'd0);
    chk("midwait_fifo_empty", 64'(port1_we), 64'd0);
    ack_en = 1'b1;
    ack_dly = 3;
    ioctl_downl = 1'b1;
    send_byte(32'h21, 32'hC3, 2, 1'b1);
    wait_drain("post_reset", 100);
    ioctl_downl = 1'b0;
    wait_loaded("post_reset", 20);

    // Randomized download
    do_reset();
    ioctl_downl = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cat = $urandom_range(0, 9);
      if (cat < 4)      addr = $urandom_range(0, BASE - 1);
      else if (cat < 9) addr = $urandom_range(BASE, BASE + SIZE - 1);
      else              addr = $urandom_range(BASE + SIZE, 32'h1FFFFFF);
      ack_dly = $urandom_range(0, 6);
      send_byte(addr, $urandom_range(0, 255), $urandom_range(10, 14), 1'b1);
    end
    ioctl_downl = 1'b0;
    wait_drain("rand", 200);
    chk("rand_dropped", 64'(dropped), 64'(exp_dropped));
    chk("rand_overflow", 64'(overflow), 64'd0);
    wait_loaded("rand", 20);

    repeat (3) @(negedge clk_sys);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
